neuron_mac: RTL

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_pkg.sv | 17 +
 rtl/neuron_clip.sv | 33 +++
 rtl/neuron_mac.sv | 86 ++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron pre-activation MAC.
package neuron_pkg;

    localparam int OPND_W   = 8;
    localparam int PROD_W   = 16;
    localparam int BIAS_W   = 16;
    localparam int OUT_W    = 9;
    localparam int CLIP_MAX = 127;
    localparam int CLIP_MIN = -127;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_OUT
    } state_t;

endpackage

// File: rtl/neuron_clip.sv
// Combinational floor-shift and symmetric clip of the accumulator into the
// 9-bit sigmoid input range; flags when the clip limits were applied.
module neuron_clip
    import neuron_pkg::*;
#(
    parameter int ACC_W     = 20,
    parameter int OUT_SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] x,
    output logic                    clipped
);

    localparam logic signed [ACC_W-1:0] HI = ACC_W'(CLIP_MAX);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(CLIP_MIN);

    logic signed [ACC_W-1:0] sh;

    always_comb begin
        // arithmetic shift rounds toward negative infinity
        sh      = acc >>> OUT_SHIFT;
        x       = sh[OUT_W-1:0];
        clipped = 1'b0;
        if (sh > HI) begin
            x       = OUT_W'(CLIP_MAX);
            clipped = 1'b1;
        end else if (sh < LO) begin
            x       = OUT_W'(CLIP_MIN);
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Neuron pre-activation MAC: bias + sum(a*w), wrapped at ACC_W, shifted and clipped.
// Define NEURON_MAC_SAT_CNT_EN to add the saturating clip counter port sat_cnt.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int ACC_W     = 20,
    parameter int OUT_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [OPND_W-1:0] in_a,
    input  logic signed [OPND_W-1:0] in_w,
    input  logic                     in_last,
    input  logic signed [BIAS_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_x,
`ifdef NEURON_MAC_SAT_CNT_EN
    output logic [15:0]              sat_cnt,
`endif
    output logic                     busy
);

    state_t                  state, state_nxt;
    logic signed [ACC_W-1:0] acc, base, acc_nxt;
    logic signed [PROD_W-1:0] prod;
    logic signed [OUT_W-1:0] clip_x;
    logic                    clip_hit;
    logic                    beat;

    assign in_ready  = (state != ST_OUT) || out_ready;
    assign beat      = in_valid && in_ready;
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);

    // Any beat outside ACC starts a new neuron, so bias replaces the old sum.
    always_comb begin
        prod    = in_a * in_w;
        base    = (state == ST_ACC) ? acc
                                    : {{(ACC_W-BIAS_W){bias[BIAS_W-1]}}, bias};
        acc_nxt = base + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

    neuron_clip #(
        .ACC_W    (ACC_W),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_clip (
        .acc    (acc_nxt),
        .x      (clip_x),
        .clipped(clip_hit)
    );

    always_comb begin
        state_nxt = state;
        if (state == ST_OUT && out_ready)
            state_nxt = ST_IDLE;
        if (beat)
            state_nxt = in_last ? ST_OUT : ST_ACC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            out_x <= '0;
        end else begin
            state <= state_nxt;
            if (beat)
                acc <= acc_nxt;
            if (beat && in_last)
                out_x <= clip_x;
        end
    end

`ifdef NEURON_MAC_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (beat && in_last && clip_hit && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
    end
`endif

endmodule
